// File: rtl/tx_serial_d4.sv
// Serial transmitter: one 4-bit word per frame, sent as start, D[0..3] LSB first,
// even parity and stop bit, each bit held for BIT_CYCLES enabled clock cycles.
module tx_serial_d4 #(
  parameter int BIT_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       valid,
  input  logic [3:0] D,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [7:0] LP_CNT_MAX = 8'(BIT_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_hold;
  logic [2:0] r_bit_idx;
  logic [7:0] r_cnt;
  logic       r_tx;
  logic       r_busy;
  logic       r_done;

  logic w_bit_end;
  logic w_last_data;
  logic w_next_data;
  logic w_parity;

  assign w_bit_end   = (r_cnt == LP_CNT_MAX);
  assign w_last_data = (r_bit_idx == 3'd3);
  assign w_next_data = r_hold[r_bit_idx[1:0] + 2'd1];
  assign w_parity    = ^r_hold;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values; reset is synchronous and outranks enable.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_hold    <= 4'd0;
      r_bit_idx <= 3'd0;
      r_cnt     <= 8'd0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (enable) begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // ready is ~r_busy, which is always 1 here, so valid alone accepts
          if (valid) begin
            r_hold    <= D;
            r_state   <= S_START;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_cnt     <= 8'd0;
            r_bit_idx <= 3'd0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= 8'd0;
            r_state <= S_DATA;
            r_tx    <= r_hold[0];
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= 8'd0;
            if (w_last_data) begin
              r_bit_idx <= 3'd0;
              r_state   <= S_PARITY;
              r_tx      <= w_parity;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= w_next_data;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= 8'd0;
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_STOP: begin
          // Done lands in the idle cycle that follows, where ready is already 1
          if (w_bit_end) begin
            r_cnt   <= 8'd0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_cnt   <= 8'd0;
        end
      endcase
    end
  end

  assign tx    = r_tx;
  assign busy  = r_busy;
  assign done  = r_done;
  assign ready = ~r_busy;

endmodule

// File: tb/tb_tx_serial_d4.sv
// Bench for tx_serial_d4: a queue-based frame model checked every cycle, plus
// directed scenarios with hand-computed bit values and timings.
module tb_tx_serial_d4;

  localparam int BC = 4;

  logic       Clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       enable = 1'b1;
  logic       valid  = 1'b0;
  logic [3:0] D      = 4'd0;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       done;

  tx_serial_d4 #(.BIT_CYCLES(BC)) dut (
    .Clk   (Clk),
    .reset (reset),
    .enable(enable),
    .valid (valid),
    .D     (D),
    .ready (ready),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a queue holding the tx level of every remaining frame cycle.
  bit         q[$];
  logic       m_tx   = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  bit         m_live = 1'b0;
  logic [6:0] m_frame;

  always @(posedge Clk) begin
    if (reset) begin
      q.delete();
      m_tx   = 1'b1;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_live = 1'b1;
    end else if (enable) begin
      m_done = 1'b0;
      if (q.size() != 0) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          m_done = 1'b1;
          m_busy = 1'b0;
          m_tx   = 1'b1;
        end else begin
          m_tx = q[0];
        end
      end else if (valid) begin
        m_frame = {1'b1, ^D, D[3], D[2], D[1], D[0], 1'b0};
        for (int b = 0; b < 7; b++)
          for (int c = 0; c < BC; c++) q.push_back(m_frame[b]);
        m_tx   = q[0];
        m_busy = 1'b1;
      end
    end
  end

  int n_done = 0;
  int run    = 0;
  int hi_runs[$];

  always @(negedge Clk) begin
    if (m_live) begin
      check("tx", {7'd0, tx}, {7'd0, m_tx});
      check("busy", {7'd0, busy}, {7'd0, m_busy});
      check("ready", {7'd0, ready}, {7'd0, ~m_busy});
      check("done", {7'd0, done}, {7'd0, m_done});
      if (done === 1'b1) n_done++;
      if (busy === 1'b1 && tx === 1'b1) run++;
      else if (run > 0) begin
        hi_runs.push_back(run);
        run = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  logic [6:0] seq30;
  logic [3:0] data31;
  int         d_before;

  initial begin
    // Reset and idle
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    check("rst_ready", {7'd0, ready}, 8'd1);
    check("rst_tx", {7'd0, tx}, 8'd1);
    step(10);
    check("idle_busy", {7'd0, busy}, 8'd0);

    // No accept while disabled
    enable = 1'b0; valid = 1'b1; D = 4'hF;
    step(3);
    check("no_accept_disabled", {7'd0, busy}, 8'd0);
    valid = 1'b0; enable = 1'b1;
    step(1);

    // D=1010: tx 0,0,1,0,1,0,1 (bit i of seq30 is frame bit i), done at cycle 29
    seq30 = 7'b1010100;
    D = 4'b1010; valid = 1'b1;
    step(1);
    valid = 1'b0;
    step(2);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("f30_bit%0d", i), {7'd0, tx}, {7'd0, seq30[i]});
      if (i < 6) step(4);
    end
    step(1);
    check("f30_done_c28", {7'd0, done}, 8'd0);
    step(1);
    check("f30_done_c29", {7'd0, done}, 8'd1);
    check("f30_ready_c29", {7'd0, ready}, 8'd1);
    step(1);
    check("f30_done_c30", {7'd0, done}, 8'd0);

    // D=0111, then D changes mid-frame and a stray valid arrives while busy
    step(2);
    data31 = 4'b0111;
    D = 4'b0111; valid = 1'b1;
    step(1);
    valid = 1'b0; D = 4'b0000;
    step(4);
    valid = 1'b1; D = 4'b1001;
    step(2);
    valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("f31_d%0d", i), {7'd0, tx}, {7'd0, data31[i]});
      step(4);
    end
    check("f31_parity", {7'd0, tx}, 8'd1);
    step(6);
    check("f31_done", {7'd0, done}, 8'd1);

    // Back-to-back: 0001 then 1111 accepted in the done cycle
    step(2);
    d_before = n_done;
    D = 4'b0001; valid = 1'b1;
    step(1);
    D = 4'b1111;
    step(28);
    check("f32_done1", {7'd0, done}, 8'd1);
    check("f32_ready1", {7'd0, ready}, 8'd1);
    step(1);
    check("f32_start2_tx", {7'd0, tx}, 8'd0);
    check("f32_start2_busy", {7'd0, busy}, 8'd1);
    valid = 1'b0;
    step(21);
    check("f32_parity2", {7'd0, tx}, 8'd0);
    step(7);
    check("f32_done2", {7'd0, done}, 8'd1);
    step(2);
    check("f32_done_count", 8'(n_done - d_before), 8'd2);

    // Enable low for 6 cycles inside D[1] of 1010
    step(2);
    hi_runs.delete();
    D = 4'b1010; valid = 1'b1;
    step(1);
    valid = 1'b0;
    step(9);
    enable = 1'b0;
    step(6);
    enable = 1'b1;
    step(22);
    check("f33_runs", 8'(hi_runs.size()), 8'd3);
    check("f33_d1_len", 8'(hi_runs.size() > 0 ? hi_runs[0] : 0), 8'd10);
    check("f33_d3_len", 8'(hi_runs.size() > 1 ? hi_runs[1] : 0), 8'd4);
    check("f33_stop_len", 8'(hi_runs.size() > 2 ? hi_runs[2] : 0), 8'd4);

    // Reset at cycle 13 of a frame, with valid held during reset
    step(2);
    d_before = n_done;
    D = 4'b0111; valid = 1'b1;
    step(1);
    valid = 1'b0;
    step(12);
    reset = 1'b1; valid = 1'b1;
    step(1);
    check("f34_tx", {7'd0, tx}, 8'd1);
    check("f34_busy", {7'd0, busy}, 8'd0);
    check("f34_ready", {7'd0, ready}, 8'd1);
    check("f34_done", {7'd0, done}, 8'd0);
    step(1);
    reset = 1'b0; valid = 1'b0;
    check("f34_no_accept_in_reset", {7'd0, busy}, 8'd0);
    step(30);
    check("f34_no_done", 8'(n_done - d_before), 8'd0);
    D = 4'b1100; valid = 1'b1;
    step(1);
    valid = 1'b0;
    check("f34_new_start", {7'd0, tx}, 8'd0);
    step(28);
    check("f34_new_done", {7'd0, done}, 8'd1);
    step(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_serial_d4.md
TX_SERIAL_D4 -- requirements
Module: tx_serial_d4

Interface
REQ-001 Parameter BIT_CYCLES, default 4, enabled clock cycles per serial bit; legal range 1..255.
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  clock enable; 0 freezes all state and outputs.
REQ-005 valid  input  1  word offered on D.
REQ-006 D  input  4  parallel data word.
REQ-007 ready  output  1  block can accept a word.
REQ-008 tx  output  1  serial line; idle level 1.
REQ-009 busy  output  1  frame in progress.
REQ-010 done  output  1  single-cycle frame-complete pulse.

Function
REQ-011 Accept condition SHALL be valid=1, ready=1, enable=1 at a rising Clk edge; D SHALL be latched into an internal 4-bit holding register at that edge.
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on accept.
- START -> DATA after BIT_CYCLES enabled cycles.
- DATA -> PARITY after 4 bits.
- PARITY -> STOP after BIT_CYCLES enabled cycles.
- STOP -> IDLE after BIT_CYCLES enabled cycles.
REQ-013 Frame SHALL be: start bit 0, D[0], D[1], D[2], D[3] (LSB first), even-parity bit (XOR of latched D), stop bit 1; 7 bits total, 7*BIT_CYCLES enabled cycles.
REQ-014 tx SHALL be registered; first start-bit cycle SHALL be the cycle immediately after the accept edge.
REQ-015 tx SHALL be 1 in IDLE.
REQ-016 busy SHALL be 1 in START, DATA, PARITY and STOP; 0 in IDLE.
REQ-017 ready SHALL equal NOT busy.
REQ-018 done SHALL be 1 for exactly one enabled cycle: the first cycle after the last stop-bit cycle, with ready=1 in that same cycle.
REQ-019 A 3-bit bit index and an 8-bit cycle counter SHALL wrap to 0 at each bit boundary; no counter SHALL exceed its terminal value.
REQ-020 valid while busy=1 SHALL be ignored; no queuing.
REQ-021 Changes on D after the accept edge SHALL NOT affect the frame in progress.
REQ-022 Back-to-back operation:
- valid=1 in the done cycle SHALL be accepted.
- The next start bit SHALL follow with no idle bit between frames.
REQ-023 enable=0 SHALL hold state, counters, tx, busy, ready and done unchanged; the bit period SHALL be stretched, never truncated.
REQ-024 Accept SHALL NOT occur while enable=0.

Reset
REQ-025 reset=1 at a rising edge SHALL force IDLE, counters=0, holding register=0, tx=1, busy=0, ready=1, done=0.
REQ-026 reset SHALL take priority over enable and valid.
REQ-027 Reset mid-frame SHALL abort the frame immediately, with tx=1 the next cycle and no done pulse.
REQ-028 valid=1 during reset SHALL NOT be accepted.

Verification (BIT_CYCLES=4)
REQ-029 Reset, then idle 10 cycles with enable=1 -> tx=1, ready=1, busy=0, done=0 throughout.
REQ-030 Accept D=4'b1010 -> tx=0,0,1,0,1,0,1 (each held 4 cycles); done=1 on cycle 29 after accept.
REQ-031 Accept D=4'b0111 -> parity bit=1; set D=4'b0000 mid-frame -> data bits remain 1,1,1,0.
REQ-032 Hold valid=1 with D=4'b0001 then D=4'b1111 across done -> two contiguous 28-cycle frames; second parity=0; single done pulse per frame.
REQ-033 Drop enable to 0 for 6 cycles inside D[1] -> that bit lasts 10 Clk cycles; frame otherwise identical.
REQ-034 Assert reset at cycle 13 of a frame -> next cycle tx=1, busy=0, ready=1; no done pulse; a new accept starts a clean frame.
